fft_64_frame_collector: RTL and testbench

FFT_64_FRAME_COLLECTOR -- requirements
Module: fft_64_frame_collector

---
 rtl/fft_64_frame_collector.sv | 209 ++++++++++++++++++++
 tb/tb_fft_64_frame_collector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_64_frame_collector.sv
// Collects 4-lane FFT output beats into ping-pong 64-sample banks and replays them serially
// over a valid/ready stream. Define FFT64_COL_BITREV_EN to read each bank in bit-reversed order.
module fft_64_frame_collector (
    input  logic        clk,
    input  logic        rst_in,
    input  logic [15:0] x_a_in,
    input  logic [15:0] y_a_in,
    input  logic [15:0] x_b_in,
    input  logic [15:0] y_b_in,
    input  logic [15:0] x_c_in,
    input  logic [15:0] y_c_in,
    input  logic [15:0] x_d_in,
    input  logic [15:0] y_d_in,
    input  logic        ctrl_in,
    output logic [15:0] x_out,
    output logic [15:0] y_out,
    output logic [5:0]  idx_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        last_out,
    output logic        overflow_out,
    output logic        resync_out
);

    typedef enum logic { W_IDLE, W_FILL } wr_state_e;
    typedef enum logic { R_EMPTY, R_DRAIN } rd_state_e;

    wr_state_e   wr_state_q, wr_state_d;
    rd_state_e   rd_state_q, rd_state_d;
    logic [3:0]  wr_cnt_q, wr_cnt_d;
    logic        wr_bank_q, wr_bank_d;
    logic        drop_q, drop_d;
    logic [1:0]  full_q, full_d;
    logic        rd_bank_q, rd_bank_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic [5:0]  idx_q, idx_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic        ovf_q, ovf_d, rsy_q, rsy_d;

    logic [31:0] mem_q [2][64];
    logic        wr_en, set_full, free, load, sel_bank;
    logic [3:0]  wr_beat;
    logic [5:0]  sel_idx;
    logic [31:0] rd_data;

    function automatic logic [5:0] rd_addr(input logic [5:0] i);
`ifdef FFT64_COL_BITREV_EN
        return {i[0], i[1], i[2], i[3], i[4], i[5]};
`else
        return i;
`endif
    endfunction

    // Writer: any ctrl_in pulse starts beat 0; in FILL that is a resync of the current bank.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        drop_d     = drop_q;
        ovf_d      = ovf_q;
        rsy_d      = rsy_q;
        wr_en      = 1'b0;
        wr_beat    = wr_cnt_q;
        set_full   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (ctrl_in) begin
                    wr_state_d = W_FILL;
                    wr_cnt_d   = 4'd1;
                    wr_beat    = 4'd0;
                    drop_d     = full_q[wr_bank_q];
                    wr_en      = !full_q[wr_bank_q];
                    if (full_q[wr_bank_q]) ovf_d = 1'b1;
                end
            end
            W_FILL: begin
                if (ctrl_in) begin
                    wr_cnt_d = 4'd1;
                    wr_beat  = 4'd0;
                    drop_d   = full_q[wr_bank_q];
                    wr_en    = !full_q[wr_bank_q];
                    rsy_d    = 1'b1;
                end else begin
                    wr_en    = !drop_q;
                    wr_cnt_d = wr_cnt_q + 4'd1;
                    if (wr_cnt_q == 4'd15) begin
                        wr_state_d = W_IDLE;
                        if (!drop_q) begin
                            set_full  = 1'b1;
                            wr_bank_d = ~wr_bank_q;
                        end
                    end
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Reader: output registers are reloaded only on a transfer, so they hold during stalls.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        valid_d    = valid_q;
        last_d     = last_q;
        idx_d      = idx_q;
        x_d        = x_q;
        y_d        = y_q;
        load       = 1'b0;
        free       = 1'b0;
        sel_bank   = rd_bank_q;
        sel_idx    = idx_q + 6'd1;
        case (rd_state_q)
            R_EMPTY: begin
                if (full_q[rd_bank_q]) begin
                    load       = 1'b1;
                    sel_idx    = 6'd0;
                    rd_state_d = R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (ready_in) begin
                    if (last_q) begin
                        free      = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        if (full_q[~rd_bank_q]) begin
                            load     = 1'b1;
                            sel_bank = ~rd_bank_q;
                            sel_idx  = 6'd0;
                        end else begin
                            valid_d    = 1'b0;
                            last_d     = 1'b0;
                            rd_state_d = R_EMPTY;
                        end
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: rd_state_d = R_EMPTY;
        endcase
        rd_data = mem_q[sel_bank][rd_addr(sel_idx)];
        if (load) begin
            valid_d = 1'b1;
            idx_d   = sel_idx;
            last_d  = (sel_idx == 6'd63);
            x_d     = rd_data[31:16];
            y_d     = rd_data[15:0];
        end
        full_d = full_q;
        if (free)     full_d[rd_bank_q] = 1'b0;
        if (set_full) full_d[wr_bank_q] = 1'b1;
    end

    // NOTE: sample storage has no reset; the full flags alone say which contents are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank_q][{wr_beat, 2'd0}] <= {x_a_in, y_a_in};
            mem_q[wr_bank_q][{wr_beat, 2'd1}] <= {x_b_in, y_b_in};
            mem_q[wr_bank_q][{wr_beat, 2'd2}] <= {x_c_in, y_c_in};
            mem_q[wr_bank_q][{wr_beat, 2'd3}] <= {x_d_in, y_d_in};
        end
    end

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_EMPTY;
            wr_cnt_q   <= 4'd0;
            wr_bank_q  <= 1'b0;
            drop_q     <= 1'b0;
            full_q     <= 2'b00;
            rd_bank_q  <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            idx_q      <= 6'd0;
            x_q        <= 16'd0;
            y_q        <= 16'd0;
            ovf_q      <= 1'b0;
            rsy_q      <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            drop_q     <= drop_d;
            full_q     <= full_d;
            rd_bank_q  <= rd_bank_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ovf_q      <= ovf_d;
            rsy_q      <= rsy_d;
        end
    end

    assign x_out        = x_q;
    assign y_out        = y_q;
    assign idx_out      = idx_q;
    assign valid_out    = valid_q;
    assign last_out     = last_q;
    assign overflow_out = ovf_q;
    assign resync_out   = rsy_q;

endmodule

// File: tb/tb_fft_64_frame_collector.sv
// Randomised bench for fft_64_frame_collector: a frame-level FIFO model (capacity two frames)
// predicts every output sample, the sticky flags and the first-sample latency.
module tb_fft_64_frame_collector;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  idx;
        logic        last;
    } sample_t;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] x_a_in = '0, y_a_in = '0, x_b_in = '0, y_b_in = '0;
    logic [15:0] x_c_in = '0, y_c_in = '0, x_d_in = '0, y_d_in = '0;
    logic        ctrl_in = 1'b0;
    logic        ready_in = 1'b0;
    logic [15:0] x_out, y_out;
    logic [5:0]  idx_out;
    logic        valid_out, last_out, overflow_out, resync_out;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          occ = 0;
    int          n_xfer = 0;
    int          last_xfer_cyc = 0;
    int          beat0_cyc = 0;
    int          ready_mode = 0;
    int          n0, c0, c1, g_meas, g_main;
    logic        exp_ovf = 1'b0;
    logic        exp_rsy = 1'b0;
    logic [15:0] fx [64];
    logic [15:0] fy [64];
    sample_t     exp_q [$];
    sample_t     mon_s;

    fft_64_frame_collector dut (
        .clk(clk), .rst_in(rst_in),
        .x_a_in(x_a_in), .y_a_in(y_a_in), .x_b_in(x_b_in), .y_b_in(y_b_in),
        .x_c_in(x_c_in), .y_c_in(y_c_in), .x_d_in(x_d_in), .y_d_in(y_d_in),
        .ctrl_in(ctrl_in),
        .x_out(x_out), .y_out(y_out), .idx_out(idx_out),
        .valid_out(valid_out), .ready_in(ready_in), .last_out(last_out),
        .overflow_out(overflow_out), .resync_out(resync_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ready_in = 1'b0;
            1:       ready_in = 1'b1;
            default: ready_in = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Which stored sample appears at output position i.
    function automatic logic [5:0] exp_addr(input int i);
        logic [5:0] v;
        logic [5:0] r;
        v = 6'(i);
`ifdef FFT64_COL_BITREV_EN
        for (int b = 0; b < 6; b++) r[b] = v[5 - b];
`else
        r = v;
`endif
        return r;
    endfunction

    task automatic push_frame();
        sample_t s;
        for (int i = 0; i < 64; i++) begin
            s.x    = fx[exp_addr(i)];
            s.y    = fy[exp_addr(i)];
            s.idx  = 6'(i);
            s.last = (i == 63);
            exp_q.push_back(s);
        end
    endtask

    task automatic random_frame();
        for (int n = 0; n < 64; n++) begin
            fx[n] = 16'($urandom);
            fy[n] = 16'($urandom);
        end
    endtask

    task automatic drive_beat(input int k, input logic ctrl);
        x_a_in = fx[4*k];     y_a_in = fy[4*k];
        x_b_in = fx[4*k + 1]; y_b_in = fy[4*k + 1];
        x_c_in = fx[4*k + 2]; y_c_in = fy[4*k + 2];
        x_d_in = fx[4*k + 3]; y_d_in = fy[4*k + 3];
        ctrl_in = ctrl;
        @(posedge clk); #1;
    endtask

    task automatic drive_junk(input logic ctrl);
        x_a_in = 16'($urandom); y_a_in = 16'($urandom);
        x_b_in = 16'($urandom); y_b_in = 16'($urandom);
        x_c_in = 16'($urandom); y_c_in = 16'($urandom);
        x_d_in = 16'($urandom); y_d_in = 16'($urandom);
        ctrl_in = ctrl;
        @(posedge clk); #1;
    endtask

    // Sends fx/fy as one frame; resync_at > 0 first sends that many junk beats.
    task automatic send_frame(input int resync_at, input bit allow_drop);
        int guard = 0;
        @(posedge clk); #1;
        while (!allow_drop && occ >= 2 && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 5000) check("room_timeout", 1, 0);
        if (occ < 2) begin
            occ++;
            push_frame();
        end else begin
            exp_ovf = 1'b1;
        end
        for (int k = 0; k < resync_at; k++) drive_junk(k == 0);
        if (resync_at > 0) exp_rsy = 1'b1;
        beat0_cyc = cyc;
        for (int k = 0; k < 16; k++) drive_beat(k, k == 0);
        ctrl_in = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        check(tag, exp_q.size(), 0);
        @(negedge clk); @(negedge clk);
        check("idle_valid", valid_out, 0);
    endtask

    task automatic check_all_zero();
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_idx", idx_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_last", last_out, 0);
        check("rst_ovf", overflow_out, 0);
        check("rst_rsy", resync_out, 0);
    endtask

    // Scoreboard: whenever valid_out is high the outputs must equal the oldest expected sample.
    always @(negedge clk) begin
        if (!rst_in && valid_out) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                mon_s = exp_q[0];
                check("x", x_out, mon_s.x);
                check("y", y_out, mon_s.y);
                check("idx", idx_out, mon_s.idx);
                check("last", last_out, mon_s.last);
                if (ready_in) begin
                    void'(exp_q.pop_front());
                    n_xfer++;
                    last_xfer_cyc = cyc;
                    if (mon_s.last) occ--;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero();
        @(posedge clk); #1;
        rst_in = 1'b0;

        // Impulse with latency measurement.
        ready_mode = 1;
        for (int n = 0; n < 64; n++) begin fx[n] = '0; fy[n] = '0; end
        fx[0] = 16'd1;
        send_frame(0, 0);
        g_main = 0;
        while (!valid_out && g_main < 100) begin @(negedge clk); g_main++; end
        check("latency", 32'(cyc - beat0_cyc), 17);
        wait_drain("impulse_drain");

        // Ramp: four frames, output must be one unbroken 256-sample burst.
        for (int n = 0; n < 64; n++) begin fx[n] = 16'(n); fy[n] = 16'(-n); end
        n0 = n_xfer;
        fork
            begin
                for (int f = 0; f < 4; f++) send_frame(0, 0);
            end
            begin
                g_meas = 0;
                while (!valid_out && g_meas < 2000) begin @(negedge clk); #1; g_meas++; end
                c0 = cyc;
                g_meas = 0;
                while (n_xfer < n0 + 256 && g_meas < 3000) begin @(negedge clk); #1; g_meas++; end
                check("ramp_timeout", 32'(g_meas < 3000), 1);
                c1 = last_xfer_cyc;
            end
        join
        check("ramp_span", 32'(c1 - c0), 255);
        wait_drain("ramp_drain");

        // Random backpressure.
        ready_mode = 2;
        for (int f = 0; f < 3; f++) begin
            random_frame();
            send_frame(0, 0);
        end
        wait_drain("bp_drain");
        check("ovf_clear", overflow_out, exp_ovf);
        check("rsy_clear", resync_out, exp_rsy);

        // Overflow: three frames with the sink stalled; the third is dropped.
        ready_mode = 0;
        for (int f = 0; f < 3; f++) begin
            random_frame();
            send_frame(0, 1);
        end
        @(negedge clk);
        check("overflow", overflow_out, exp_ovf);
        ready_mode = 1;
        wait_drain("ovf_drain");

        // Resync at beat 7.
        random_frame();
        send_frame(7, 0);
        @(negedge clk);
        check("resync", resync_out, exp_rsy);
        wait_drain("rsy_drain");

        // Reset in the middle of a drain.
        random_frame();
        send_frame(0, 0);
        g_main = 0;
        do begin
            @(negedge clk);
            g_main++;
        end while (!(valid_out && idx_out == 6'd30) && g_main < 500);
        check("reach_30", 32'(g_main < 500), 1);
        #2 rst_in = 1'b1;
        #1 check_all_zero();
        exp_q.delete();
        occ = 0;
        exp_ovf = 1'b0;
        exp_rsy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_in = 1'b0;
        random_frame();
        send_frame(0, 0);
        wait_drain("post_rst_drain");
        check("final_ovf", overflow_out, exp_ovf);
        check("final_rsy", resync_out, exp_rsy);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
